// File: rtl/fifod2mac_pkg.sv
// rtl/fifod2mac_pkg.sv - shared widths, defaults and FSM state codes for fifod2mac
package fifod2mac_pkg;
  localparam int LEN_W       = 12;
  localparam int MAX_LEN_DEF = 1472;
  localparam int TIMEOUT_DEF = 65535;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_LOAD      = 3'd1;
  localparam state_t S_START     = 3'd2;
  localparam state_t S_PRIME     = 3'd3;
  localparam state_t S_STREAM    = 3'd4;
  localparam state_t S_WAIT_DONE = 3'd5;
  localparam state_t S_DONE      = 3'd6;
endpackage

// File: rtl/fifod2mac_tx_prefetch.sv
// rtl/fifod2mac_tx_prefetch.sv - FIFO prefetch: hold register, read enable and byte counter
module fifod2mac_tx_prefetch
  import fifod2mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             prime,
  input  logic             take,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       fifod_rxd,
  output logic             fifod_rxen,
  output logic [7:0]       data,
  output logic             last
);
  logic             pend;
  logic [7:0]       hold;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nx;

  assign cnt_nx     = cnt + 1'b1;
  assign last       = (cnt_nx == len);
  assign fifod_rxen = prime | (take & (cnt_nx < len));
  // A byte read last cycle is on fifod_rxd now; bypass so back-to-back requests see it before hold loads.
  assign data       = pend ? fifod_rxd : hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
      hold <= 8'd0;
      cnt  <= '0;
    end else begin
      pend <= fifod_rxen;
      if (pend)
        hold <= fifod_rxd;
      if (clear)
        cnt <= '0;
      else if (take)
        cnt <= cnt_nx;
    end
  end
endmodule

// File: rtl/fifod2mac.sv
// rtl/fifod2mac.sv - bridge from the ADC data FIFO to the mac UDP transmit interface
module fifod2mac
  import fifod2mac_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs,
  output logic             fd,
  output logic             err,
  input  logic [LEN_W-1:0] eth_tx_len,
  output logic             fifod_rxen,
  input  logic [7:0]       fifod_rxd,
  output logic             fs_udp_tx,
  input  logic             fd_udp_tx,
  output logic [LEN_W-1:0] udp_tx_len,
  input  logic             flag_udp_tx_prep,
  input  logic             flag_udp_tx_req,
  output logic [7:0]       udp_txd,
  output logic             udp_txen
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic             fs_q;
  logic [LEN_W-1:0] len;
  logic [TO_W-1:0]  wcnt;
  logic             take;
  logic             waiting;
  logic             timeout;
  logic             last;
  logic [7:0]       data;

  assign take     = (state == S_STREAM) & flag_udp_tx_req;
  assign waiting  = ((state == S_START) & ~flag_udp_tx_prep) |
                    ((state == S_STREAM) & ~flag_udp_tx_req) |
                    ((state == S_WAIT_DONE) & ~fd_udp_tx);
  assign timeout  = waiting & (wcnt == TO_W'(TIMEOUT - 1));

  assign fd         = (state == S_DONE);
  assign udp_tx_len = len;
  assign udp_txen   = take;
  assign udp_txd    = (state == S_STREAM) ? data : 8'd0;

  fifod2mac_tx_prefetch u_prefetch (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == S_LOAD),
    .prime      (state == S_PRIME),
    .take       (take),
    .len        (len),
    .fifod_rxd  (fifod_rxd),
    .fifod_rxen (fifod_rxen),
    .data       (data),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      fs_q      <= 1'b0;
      len       <= '0;
      wcnt      <= '0;
      err       <= 1'b0;
      fs_udp_tx <= 1'b0;
    end else begin
      fs_q <= fs;
      wcnt <= waiting ? wcnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (fs && !fs_q) begin
          state <= S_LOAD;
          if (eth_tx_len > LEN_W'(MAX_LEN)) begin
            len <= LEN_W'(MAX_LEN);
            err <= 1'b1;
          end else begin
            len <= eth_tx_len;
          end
        end
        S_LOAD: begin
          if (len == '0) begin
            state <= S_DONE;
          end else begin
            state     <= S_START;
            fs_udp_tx <= 1'b1;
          end
        end
        S_START, S_STREAM, S_WAIT_DONE: begin
          if (timeout) begin
            err       <= 1'b1;
            fs_udp_tx <= 1'b0;
            state     <= S_DONE;
          end else if (state == S_START && flag_udp_tx_prep) begin
            state <= S_PRIME;
          end else if (state == S_STREAM && take && last) begin
            state <= S_WAIT_DONE;
          end else if (state == S_WAIT_DONE && fd_udp_tx) begin
            fs_udp_tx <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_PRIME: state <= S_STREAM;
        S_DONE:  if (!fs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
